// File: rtl/divider_controller.sv
// divider_controller: sequencing FSM for the restoring fixed-point divider datapath.
// Divide-by-zero detection is built only when DIV_ZERO_CHECK_EN is defined.
module divider_controller #(
  parameter int ITER = 14
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic co,
  input  logic borrow,
  input  logic dvsr_zero,
  output logic ld_dvd,
  output logic ld_dvs,
  output logic ld_acc,
  output logic sclr,
  output logic cnt_en,
  output logic shl,
  output logic ld_rem,
  output logic q_bit,
  output logic busy,
  output logic valid,
  output logic dvz
);
  typedef enum logic [2:0] {IDLE = 3'd0, LOAD = 3'd1, CHECK = 3'd2, CALC = 3'd3, DONE = 3'd4} state_t;
  state_t state_q, state_d;
  logic zero_go;
`ifdef DIV_ZERO_CHECK_EN
  logic dvz_q, dvz_d;
  assign zero_go = dvsr_zero;
  // Cleared on the edge entering LOAD, set on the edge leaving CHECK towards DONE.
  always_comb dvz_d = (state_q == IDLE && start) ? 1'b0 : (state_q == CHECK && dvsr_zero) ? 1'b1 : dvz_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) dvz_q <= 1'b0;
    else dvz_q <= dvz_d;
  assign dvz = dvz_q;
`else
  logic unused_dvsr_zero;
  assign unused_dvsr_zero = dvsr_zero;
  assign zero_go = 1'b0;
  assign dvz = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? LOAD : IDLE;
      LOAD:    state_d = CHECK;
      CHECK:   state_d = zero_go ? DONE : CALC;
      CALC:    state_d = co ? DONE : CALC;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    ld_dvd = state_q == LOAD;
    ld_dvs = state_q == LOAD;
    ld_acc = state_q == LOAD;
    sclr   = state_q == LOAD;
    cnt_en = state_q == CALC;
    shl    = state_q == CALC;
    q_bit  = state_q == CALC && !borrow;
    ld_rem = state_q == CALC && !borrow;
    busy   = state_q != IDLE;
    valid  = state_q == DONE;
  end
  // A normal completion must be preceded by exactly ITER CALC cycles after CHECK.
  assert property (@(posedge clk) disable iff (!rst)
    (state_q == DONE && $past(state_q == CALC)) |-> ($past(state_q == CALC, ITER) && $past(state_q == CHECK, ITER + 1)));
endmodule
